// File: rtl/bram_portb_arbiter_if.sv
// Client and BRAM port-B bus bundle for bram_portb_arbiter.
// The arbiter takes the slave view; VGA/aux clients and the BRAM model take the master view.
interface bram_portb_arbiter_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  vga_req;
   logic [ADDR_WIDTH-1:0] vga_addr;
   logic [WIDTH-1:0]      vga_data;
   logic                  vga_valid;

   logic [1:0]            aux_req;
   logic [1:0]            aux_we;
   logic [ADDR_WIDTH-1:0] aux0_addr;
   logic [ADDR_WIDTH-1:0] aux1_addr;
   logic [WIDTH-1:0]      aux0_wdata;
   logic [WIDTH-1:0]      aux1_wdata;
   logic [1:0]            aux_gnt;
   logic [WIDTH-1:0]      aux_rdata;
   logic [1:0]            aux_rvalid;
   logic [1:0]            aux_starved;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_data;
   logic                  mem_we;
   logic [WIDTH-1:0]      mem_q;

   modport slave (
      input  vga_req, vga_addr, aux_req, aux_we, aux0_addr, aux1_addr,
             aux0_wdata, aux1_wdata, mem_q,
      output vga_data, vga_valid, aux_gnt, aux_rdata, aux_rvalid, aux_starved,
             mem_addr, mem_data, mem_we
   );

   modport master (
      output vga_req, vga_addr, aux_req, aux_we, aux0_addr, aux1_addr,
             aux0_wdata, aux1_wdata, mem_q,
      input  vga_data, vga_valid, aux_gnt, aux_rdata, aux_rvalid, aux_starved,
             mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/bram_portb_arbiter.sv
// BRAM port-B arbiter: VGA reads have absolute priority, two aux clients share idle slots
// round-robin. Read data returns one cycle after the grant under a per-client valid strobe.
module bram_portb_arbiter #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input logic                 clk,
   input logic                 reset,
   bram_portb_arbiter_if.slave bus
);

   localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnVga  = 2'd1,
      OwnAux0 = 2'd2,
      OwnAux1 = 2'd3
   } owner_e;

   owner_e          owner_q, owner_d;
   logic            rr_q, rr_d;
   logic [1:0][7:0] starve_q, starve_d;
   logic [1:0]      starved_q, starved_d;
   logic [1:0]      aux_req_ok;
   logic [1:0]      gnt;

   // Aux requests are masked while reset is held so nothing is granted during reset.
   assign aux_req_ok = bus.aux_req & {2{reset}};

   always_comb begin
      gnt = 2'b00;
      if (!bus.vga_req) begin
         unique case (aux_req_ok)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Port-B mux, owner next state and round-robin pointer update.
   always_comb begin
      bus.mem_addr = '0;
      bus.mem_data = '0;
      bus.mem_we   = 1'b0;
      owner_d      = OwnNone;
      rr_d         = rr_q;
      if (bus.vga_req) begin
         bus.mem_addr = bus.vga_addr;
         owner_d      = OwnVga;
      end else if (gnt[0]) begin
         bus.mem_addr = bus.aux0_addr;
         bus.mem_data = bus.aux0_wdata;
         bus.mem_we   = bus.aux_we[0];
         owner_d      = bus.aux_we[0] ? OwnNone : OwnAux0;
         rr_d         = 1'b1;
      end else if (gnt[1]) begin
         bus.mem_addr = bus.aux1_addr;
         bus.mem_data = bus.aux1_wdata;
         bus.mem_we   = bus.aux_we[1];
         owner_d      = bus.aux_we[1] ? OwnNone : OwnAux1;
         rr_d         = 1'b0;
      end
   end

   // Starve counters saturate at 255 and clear on grant or withdrawal.
   always_comb begin
      starve_d  = starve_q;
      starved_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!bus.aux_req[i] || gnt[i]) begin
            starve_d[i] = 8'd0;
         end else if (starve_q[i] != 8'hFF) begin
            starve_d[i] = starve_q[i] + 8'd1;
         end
         starved_d[i] = (starve_d[i] >= StarveLimit);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q   <= OwnNone;
         rr_q      <= 1'b0;
         starve_q  <= '0;
         starved_q <= 2'b00;
      end else begin
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         starve_q  <= starve_d;
         starved_q <= starved_d;
      end
   end

   assign bus.aux_gnt     = gnt;
   assign bus.vga_data    = bus.mem_q;
   assign bus.aux_rdata   = bus.mem_q;
   assign bus.vga_valid   = (owner_q == OwnVga);
   assign bus.aux_rvalid  = {owner_q == OwnAux1, owner_q == OwnAux0};
   assign bus.aux_starved = starved_q;

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
   a_vga_first : assert property (@(posedge clk) disable iff (!reset)
                                  bus.vga_req |-> (gnt == 2'b00));
   a_strobe_onehot : assert property (@(posedge clk) disable iff (!reset)
                                      $onehot0({bus.vga_valid, bus.aux_rvalid}));

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter: read responses go through an expected-response queue
// checked by an independent monitor; grants and port-B drive are checked in-line.
module tb_bram_portb_arbiter;

   localparam int KVga  = 0;
   localparam int KAux0 = 1;
   localparam int KAux1 = 2;

   typedef struct {
      int          kind;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] ram [1024];
   logic [15:0] q_b = 16'h0000;
   exp_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   bram_portb_arbiter_if #(.WIDTH(16), .ADDR_WIDTH(10)) bus ();

   bram_portb_arbiter #(
      .WIDTH(16),
      .ADDR_WIDTH(10),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #10 clk = ~clk;

   // BRAM port B, clocked on the falling edge.
   always @(negedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
      q_b <= ram[bus.mem_addr];
   end
   assign bus.mem_q = q_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push(input int kind, input logic [15:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the oldest expected response.
   initial begin
      forever begin
         int kind;
         logic [15:0] data;
         exp_t e;
         @(posedge clk);
         #3;
         if (bus.vga_valid || (bus.aux_rvalid != 2'b00)) begin
            unique case ({bus.vga_valid, bus.aux_rvalid})
               3'b100:  begin kind = KVga;  data = bus.vga_data;  end
               3'b001:  begin kind = KAux0; data = bus.aux_rdata; end
               3'b010:  begin kind = KAux1; data = bus.aux_rdata; end
               default: begin kind = 9;     data = bus.aux_rdata; end
            endcase
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_strobe: got kind %0d data %0h expected no strobe at %0t",
                        kind, data, $time);
            end else begin
               e = exp_q.pop_front();
               check("strobe_owner", 32'(kind), 32'(e.kind));
               check("strobe_data", 32'(data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
      ram[10'h010] = 16'h1111;
      ram[10'h020] = 16'h2222;
      ram[10'h123] = 16'hBEEF;
      ram[10'h200] = 16'hC0DE;

      // Reset held with every request high.
      bus.vga_req    = 1'b1;
      bus.vga_addr   = 10'h123;
      bus.aux_req    = 2'b11;
      bus.aux_we     = 2'b00;
      bus.aux0_addr  = 10'h010;
      bus.aux1_addr  = 10'h020;
      bus.aux0_wdata = 16'h0000;
      bus.aux1_wdata = 16'h0000;
      repeat (3) next_cycle();
      bus.vga_req = 1'b0;
      #1;
      check("rst_gnt", 32'(bus.aux_gnt), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      check("rst_vga_valid", 32'(bus.vga_valid), 0);
      check("rst_aux_rvalid", 32'(bus.aux_rvalid), 0);
      check("rst_starved", 32'(bus.aux_starved), 0);
      bus.aux_req = 2'b00;
      next_cycle();
      reset = 1'b1;

      // Round-robin between two held read requests; first grant shows rr reset to 0.
      next_cycle();
      bus.aux_req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (i % 2 == 0) begin
            check("rr_gnt_aux0", 32'(bus.aux_gnt), 1);
            check("rr_addr_aux0", 32'(bus.mem_addr), 32'h010);
            push(KAux0, 16'h1111);
         end else begin
            check("rr_gnt_aux1", 32'(bus.aux_gnt), 2);
            check("rr_addr_aux1", 32'(bus.mem_addr), 32'h020);
            push(KAux1, 16'h2222);
         end
         next_cycle();
      end
      bus.aux_req = 2'b00;
      next_cycle();

      // Plain VGA read.
      bus.vga_req  = 1'b1;
      bus.vga_addr = 10'h123;
      #1;
      check("vga_addr", 32'(bus.mem_addr), 32'h123);
      check("vga_we", 32'(bus.mem_we), 0);
      check("vga_gnt", 32'(bus.aux_gnt), 0);
      push(KVga, 16'hBEEF);
      next_cycle();
      bus.vga_req = 1'b0;
      next_cycle();

      // VGA and both aux in the same cycle: VGA only, then aux0, then aux1.
      bus.vga_req  = 1'b1;
      bus.vga_addr = 10'h200;
      bus.aux_req  = 2'b11;
      #1;
      check("conflict_gnt", 32'(bus.aux_gnt), 0);
      check("conflict_addr", 32'(bus.mem_addr), 32'h200);
      push(KVga, 16'hC0DE);
      next_cycle();
      bus.vga_req = 1'b0;
      #1;
      check("after_conflict_gnt", 32'(bus.aux_gnt), 1);
      push(KAux0, 16'h1111);
      next_cycle();
      #1;
      check("after_conflict_gnt2", 32'(bus.aux_gnt), 2);
      push(KAux1, 16'h2222);
      next_cycle();
      bus.aux_req = 2'b00;
      next_cycle();

      // aux0 write, then read back the same address.
      bus.aux_req    = 2'b01;
      bus.aux_we     = 2'b01;
      bus.aux0_addr  = 10'h3F0;
      bus.aux0_wdata = 16'hA5A5;
      #1;
      check("wr_gnt", 32'(bus.aux_gnt), 1);
      check("wr_we", 32'(bus.mem_we), 1);
      check("wr_addr", 32'(bus.mem_addr), 32'h3F0);
      check("wr_data", 32'(bus.mem_data), 32'hA5A5);
      next_cycle();
      bus.aux_we = 2'b00;
      #1;
      check("rd_gnt", 32'(bus.aux_gnt), 1);
      check("rd_we", 32'(bus.mem_we), 0);
      push(KAux0, 16'hA5A5);
      next_cycle();
      bus.aux_req   = 2'b00;
      bus.aux0_addr = 10'h010;
      next_cycle();

      // Starvation of aux1 under continuous VGA traffic.
      bus.vga_req  = 1'b1;
      bus.vga_addr = 10'h123;
      bus.aux_req  = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("starve_gnt", 32'(bus.aux_gnt), 0);
         check("starve_flag", 32'(bus.aux_starved), (i == 4) ? 2 : 0);
         push(KVga, 16'hBEEF);
         next_cycle();
      end
      bus.vga_req = 1'b0;
      #1;
      check("starve_release_gnt", 32'(bus.aux_gnt), 2);
      check("starve_flag_held", 32'(bus.aux_starved), 2);
      push(KAux1, 16'h2222);
      next_cycle();
      bus.aux_req = 2'b00;
      #1;
      check("starve_flag_clear", 32'(bus.aux_starved), 0);
      next_cycle();

      // Reset mid-read: the pending strobe is dropped and rr returns to 0.
      bus.vga_req = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      bus.vga_req = 1'b0;
      check("midrst_vga_valid", 32'(bus.vga_valid), 0);
      repeat (2) next_cycle();
      reset = 1'b1;
      next_cycle();
      check("midrst_no_strobe", 32'(bus.vga_valid), 0);
      bus.aux_req = 2'b11;
      #1;
      check("midrst_rr_gnt", 32'(bus.aux_gnt), 1);
      push(KAux0, 16'h1111);
      next_cycle();
      bus.aux_req = 2'b00;
      repeat (3) next_cycle();

      check("queue_drain", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bram_portb_arbiter.md
# bram_portb_arbiter

Shares port B of the dual-port frame/data BRAM between the VGA scan-out reader and two auxiliary clients (aux0, aux1: e.g. a sprite-copy engine and an input-event logger). VGA reads have absolute priority. The aux clients are served round-robin in idle slots using a req/gnt handshake. Read data returns one cycle after grant with a per-client valid strobe. Sits between `vgaControl`/aux engines and the BRAM B port, which is clocked on `~clk`.

## Interface
- `WIDTH`, 16, data word width
- `ADDR_WIDTH`, 10, BRAM address width
- `STARVE_LIMIT`, 64, pending cycles before an aux starve flag asserts (1..255)

- `clk`  in  1  system clock (50 MHz); all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `vga_req`  in  1  VGA read request this cycle
- `vga_addr`  in  ADDR_WIDTH  VGA read address
- `vga_data`  out  WIDTH  read data (shared bus = `mem_q`)
- `vga_valid`  out  1  `vga_data` holds the VGA read issued last cycle
- `aux_req[1:0]`  in  2  aux request, held until granted
- `aux_we[1:0]`  in  2  1 = write, 0 = read
- `aux0_addr`, `aux1_addr`  in  ADDR_WIDTH  aux addresses
- `aux0_wdata`, `aux1_wdata`  in  WIDTH  aux write data
- `aux_gnt[1:0]`  out  2  combinational one-cycle grant
- `aux_rdata`  out  WIDTH  read data (shared bus = `mem_q`)
- `aux_rvalid[1:0]`  out  2  aux read data valid
- `aux_starved[1:0]`  out  2  pending count ≥ `STARVE_LIMIT`
- `mem_addr`  out  ADDR_WIDTH  to BRAM `addr_b`
- `mem_data`  out  WIDTH  to BRAM `data_b`
- `mem_we`  out  1  to BRAM `we_b`
- `mem_q`  in  WIDTH  from BRAM `q_b`

## Operation
- Grant decision is combinational each cycle:
  - `vga_req` = 1 → VGA wins. No aux grant. `mem_we` = 0, `mem_addr` = `vga_addr`.
  - Otherwise, any `aux_req` → winner chosen by round-robin pointer `rr`. `rr` = 0 means aux0 has priority.
  - Winner gets `aux_gnt[i]` = 1. `mem_addr`/`mem_data`/`mem_we` come from client i.
  - After a grant to client i, `rr` ← ~i. A lone requester is granted regardless of `rr`.
  - No request → `mem_we` = 0, `mem_addr` = 0, `mem_data` = 0.
- Owner register (2 bits: NONE, VGA, AUX0, AUX1):
  - Loads the winner of a read slot.
  - Loads NONE for a write slot or an idle slot.
  - Drives the registered valid strobes: `vga_valid`, `aux_rvalid[i]`.
- `vga_data` and `aux_rdata` are both wired to `mem_q`. They are only meaningful under their valid strobe.
- Handshake:
  - Aux client holds `req`, `we`, `addr`, `wdata` stable until it samples `gnt` = 1.
  - Dropping `req` before grant is legal (request withdrawn).
  - `req` still high in the cycle after `gnt` is a new request.
- Writes commit at the BRAM's falling edge inside the grant cycle. A read to the same address in any later cycle returns the new data.
- Starve counters, one 8-bit counter per aux client:
  - Increment, saturating at 255, each cycle `aux_req[i]` = 1 and `aux_gnt[i]` = 0.
  - Clear on grant or when `req` drops.
  - `aux_starved[i]` = (count ≥ `STARVE_LIMIT`), registered.
  - Informational only; never overrides VGA priority.

## Timing
- Reset (async assert, sync-safe deassert):
  - owner = NONE; `vga_valid` = 0, `aux_rvalid` = 00.
  - `rr` = 0; starve counters = 0; `aux_starved` = 00.
  - Combinational outputs follow inputs; no grants while reset is low.
- Read latency: request granted in cycle N → data and valid in cycle N+1. Valid is high for exactly one cycle.
- Back-to-back reads: one per cycle sustained. Valid strobes pipeline with no bubble.
- Write: no response strobe. `aux_gnt` in cycle N is the completion.
- VGA at 25 MHz pixel rate requests ≤ every other cycle, which guarantees aux slots. A continuous `vga_req` starves aux indefinitely; this is legal and `aux_starved` reports it.
- Reset asserted mid-transaction: a pending valid strobe is dropped. No strobe appears after reset releases.

## Test plan
- Reset: hold `reset` = 0 with all reqs high → `aux_gnt` = 00, all valids 0, `mem_we` = 0. Release → `rr` = 0.
- VGA read: `vga_req` = 1, `vga_addr` = 0x123 (BRAM[0x123] = 0xBEEF) in cycle N → `mem_addr` = 0x123 in N; `vga_valid` = 1 and `vga_data` = 0xBEEF in N+1 only.
- Aux write then read: aux0 writes 0xA5A5 to 0x3F0 (`gnt` in N). Aux0 reads 0x3F0 in N+1 → `aux_rvalid[0]` = 1, `aux_rdata` = 0xA5A5 in N+2.
- Round-robin: aux0 and aux1 both hold read requests for 4 cycles, no VGA → grants aux0, aux1, aux0, aux1. `aux_rvalid` follows one cycle later in the same order.
- Priority conflict: `vga_req` = 1 and `aux_req` = 11 in the same cycle → only VGA served. Next cycle, with `vga_req` = 0, aux0 is granted.
- Starvation: `STARVE_LIMIT` = 4, `vga_req` held high, `aux_req[1]` = 1 → `aux_starved[1]` rises after 4 pending cycles. Drop `vga_req` → aux1 granted, flag clears the next cycle.
